// File: rtl/cs_sequencer_pkg.sv
// cs_seq_pkg: opcodes, datapath control codes and sequencer states.
// CS_SEQ_STEP_EN adds the WAIT_STEP state.
package cs_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDA  = 4'h1,
        OP_LDB  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_SAVB = 4'h5,
        OP_RSTB = 4'h6,
        OP_JMP  = 4'h7,
        OP_JZ   = 4'h8,
        OP_HLT  = 4'hF
    } opcode_e;

    localparam logic [4:0] CS_NOP  = 5'b00000;
    localparam logic [4:0] CS_LDA  = 5'b10001;
    localparam logic [4:0] CS_LDB  = 5'b10010;
    localparam logic [4:0] CS_ADD  = 5'b10100;
    localparam logic [4:0] CS_SUB  = 5'b10101;
    localparam logic [4:0] CS_WRA  = 5'b10110;
    localparam logic [4:0] CS_SAVB = 5'b11100;
    localparam logic [4:0] CS_RSTB = 5'b11101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC1,
        S_EXEC2,
`ifdef CS_SEQ_STEP_EN
        S_WAIT_STEP,
`endif
        S_HALT
    } state_e;

endpackage

// File: rtl/cs_sequencer_if.sv
// cs_sequencer_if: instruction-memory fetch bus between sequencer and memory.
interface cs_sequencer_if;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] instr;
    modport master (output mem_req, input mem_ack, input instr);
    modport slave  (input mem_req, output mem_ack, output instr);
endinterface

// File: rtl/cs_sequencer_decode.sv
// cs_decode: maps an opcode to its EXEC1/EXEC2 control codes and flow flags.
module cs_decode
    import cs_seq_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opc_i,
    output logic [4:0]       cs1_o,
    output logic [4:0]       cs2_o,
    output logic             two_cycle_o,
    output logic             jump_o,
    output logic             cond_o,
    output logic             halt_o
);
    opcode_e op;
    assign op = opcode_e'(4'(opc_i));
    always_comb begin
        two_cycle_o = (op == OP_ADD) || (op == OP_SUB);
        jump_o      = (op == OP_JMP) || (op == OP_JZ);
        cond_o      = (op == OP_JZ);
        halt_o      = (op == OP_HLT);
        cs1_o       = op == OP_LDA  ? CS_LDA  :
                      op == OP_LDB  ? CS_LDB  :
                      op == OP_ADD  ? CS_ADD  :
                      op == OP_SUB  ? CS_SUB  :
                      op == OP_SAVB ? CS_SAVB :
                      op == OP_RSTB ? CS_RSTB : CS_NOP;
        cs2_o       = two_cycle_o ? CS_WRA : CS_NOP;
    end
endmodule

// File: rtl/cs_sequencer.sv
// cs_sequencer: fetch/decode/execute control sequencer for a small datapath.
// CS_SEQ_STEP_EN adds a step input that gates each fetch after an instruction.
module cs_sequencer
    import cs_seq_pkg::*;
#(
    parameter int PC_W  = 4,
    parameter int OPC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef CS_SEQ_STEP_EN
    input  logic             step,
`endif
    input  logic             zero,
    cs_sequencer_if.master   mem,
    output logic [PC_W-1:0]  pc,
    output logic [4:0]       cs,
    output logic [3:0]       operand,
    output logic             busy,
    output logic             halted
);
`ifdef CS_SEQ_STEP_EN
    localparam state_e DONE_ST = S_WAIT_STEP;
`else
    localparam state_e DONE_ST = S_FETCH;
`endif

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [3:0]       opd_q, opd_d;
    logic [4:0]       cs1, cs2;
    logic             two_cycle, jump, cond, halt;

    cs_decode #(.OPC_W(OPC_W)) u_dec (
        .opc_i       (opc_q),
        .cs1_o       (cs1),
        .cs2_o       (cs2),
        .two_cycle_o (two_cycle),
        .jump_o      (jump),
        .cond_o      (cond),
        .halt_o      (halt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            opc_q   <= '0;
            opd_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            opd_q   <= opd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        opc_d       = opc_q;
        opd_d       = opd_q;
        mem.mem_req = 1'b0;
        cs          = CS_NOP;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    opc_d   = mem.instr[7 -: OPC_W];
                    opd_d   = mem.instr[3:0];
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC1;
            S_EXEC1: begin
                cs      = cs1;
                // zero is only meaningful here, for JZ
                pc_d    = (jump && (!cond || zero)) ? PC_W'(opd_q) : pc_q;
                state_d = halt ? S_HALT : two_cycle ? S_EXEC2 : DONE_ST;
            end
            S_EXEC2: begin
                cs      = cs2;
                state_d = DONE_ST;
            end
`ifdef CS_SEQ_STEP_EN
            S_WAIT_STEP: state_d = step ? S_FETCH : S_WAIT_STEP;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign pc      = pc_q;
    assign operand = opd_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted  = (state_q == S_HALT);
endmodule

// File: tb/tb_cs_sequencer.sv
// tb_cs_sequencer: directed program walk-through with hand-computed expectations.
module tb_cs_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       zero = 1'b0;
`ifdef CS_SEQ_STEP_EN
    logic       step = 1'b0;
`endif
    logic [3:0] pc;
    logic [4:0] cs;
    logic [3:0] operand;
    logic       busy;
    logic       halted;
    int         total = 0;
    int         passed = 0;
    int         failed = 0;

    cs_sequencer_if m ();

    always #5 clk = ~clk;

    cs_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
`ifdef CS_SEQ_STEP_EN
        .step    (step),
`endif
        .zero    (zero),
        .mem     (m),
        .pc      (pc),
        .cs      (cs),
        .operand (operand),
        .busy    (busy),
        .halted  (halted)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [7:0] w, input int d, input logic [3:0] pc0);
        logic [3:0] nx;
        nx = pc0 + 4'd1;
        chk("fetch_req", 32'(m.mem_req), 1);
        chk("fetch_pc", 32'(pc), 32'(pc0));
        for (int i = 0; i < d; i++) begin
            tick;
            chk("req_hold", 32'(m.mem_req), 1);
            chk("pc_hold", 32'(pc), 32'(pc0));
        end
        m.mem_ack = 1'b1;
        m.instr   = w;
        tick;
        m.mem_ack = 1'b0;
        m.instr   = 8'h00;
        chk("dec_req", 32'(m.mem_req), 0);
        chk("dec_pc", 32'(pc), 32'(nx));
        chk("dec_cs", 32'(cs), 0);
        chk("dec_busy", 32'(busy), 1);
    endtask

    task automatic gap;
`ifdef CS_SEQ_STEP_EN
        chk("ws_req", 32'(m.mem_req), 0);
        chk("ws_busy", 32'(busy), 1);
        tick;
        chk("ws_hold", 32'(m.mem_req), 0);
        step = 1'b1;
        tick;
        step = 1'b0;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        m.mem_ack = 1'b0;
        m.instr   = 8'h00;
        tick;
        tick;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_cs", 32'(cs), 0);
        chk("rst_opd", 32'(operand), 0);
        chk("rst_req", 32'(m.mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halt", 32'(halted), 0);
        reset = 1'b1;
        tick;
        chk("idle_busy", 32'(busy), 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        // LDB 5
        fetch(8'h25, 0, 4'h0);
        tick;
        chk("ldb_cs", 32'(cs), 32'h12);
        chk("ldb_opd", 32'(operand), 5);
        chk("ldb_pc", 32'(pc), 1);
        tick;
        gap;
        // ADD 3
        fetch(8'h33, 0, 4'h1);
        tick;
        chk("add_cs1", 32'(cs), 32'h14);
        tick;
        chk("add_cs2", 32'(cs), 32'h16);
        tick;
        gap;
        // JZ 9, not taken
        fetch(8'h89, 0, 4'h2);
        tick;
        chk("jz0_cs", 32'(cs), 0);
        tick;
        gap;
        // JZ 9, taken
        zero = 1'b1;
        fetch(8'h89, 0, 4'h3);
        tick;
        tick;
        zero = 1'b0;
        gap;
        // JMP F with slow memory
        fetch(8'h7F, 3, 4'h9);
        tick;
        tick;
        gap;
        // NOP at F wraps pc
        fetch(8'h00, 0, 4'hF);
        tick;
        chk("nop_cs", 32'(cs), 0);
        tick;
        gap;
        // SUB 1, reset during EXEC2
        fetch(8'h41, 0, 4'h0);
        tick;
        chk("sub_cs1", 32'(cs), 32'h15);
        tick;
        chk("sub_cs2", 32'(cs), 32'h16);
        #1 reset = 1'b0;
        #1;
        chk("arst_pc", 32'(pc), 0);
        chk("arst_cs", 32'(cs), 0);
        chk("arst_opd", 32'(operand), 0);
        chk("arst_req", 32'(m.mem_req), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_halt", 32'(halted), 0);
        tick;
        reset = 1'b1;
        tick;
        tick;
        chk("post_rst_req", 32'(m.mem_req), 0);
        chk("post_rst_busy", 32'(busy), 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        // HLT, start ignored while busy
        fetch(8'hF0, 0, 4'h0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("hlt_ign_pc", 32'(pc), 1);
        chk("hlt_ign_busy", 32'(busy), 1);
        tick;
        chk("halt_flag", 32'(halted), 1);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_req", 32'(m.mem_req), 0);
        tick;
        chk("halt_stay", 32'(halted), 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("restart_halt", 32'(halted), 0);
        // SAVB 3
        fetch(8'h53, 0, 4'h0);
        tick;
        chk("savb_cs", 32'(cs), 32'h1C);
        chk("savb_opd", 32'(operand), 3);
        tick;
        gap;
        // RSTB 2
        fetch(8'h62, 0, 4'h1);
        tick;
        chk("rstb_cs", 32'(cs), 32'h1D);
        tick;
        gap;
        chk("end_req", 32'(m.mem_req), 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
